// File: rtl/timing_control_gen.sv
// rtl/timing_control_gen.sv - carrier-derived tick/second/frame timing with phase lock (optional watchdog: TIMING_CTRL_WATCHDOG_EN)
module timing_control_gen #(
    parameter int DIV_W         = 9,
    parameter int TICKS_PER_SEC = 250,
    parameter int FRAME_SEC     = 16,
    parameter int ADDR_W        = 12,
    parameter int LOCK_COUNT    = 4,
    parameter int WD_LIMIT      = 1250000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              carrier_pulse,
    input  logic [DIV_W-1:0]  carrier_div,
    input  logic [7:0]        marker_phase,
    input  logic              phase_valid,
    output logic [DIV_W-1:0]  carrier_counter,
    output logic [7:0]        tick_counter,
    output logic [ADDR_W-1:0] address_counter,
    output logic              tick_pulse,
    output logic [3:0]        write_second_bram,
    output logic              one_sec_marker,
    output logic              frame_start,
    output logic              locked,
    output logic              carrier_lost
);
    localparam int FRAME_TICKS = TICKS_PER_SEC * FRAME_SEC;

    typedef enum logic [1:0] {HUNT, QUAL, LOCKED} state_t;

    state_t            state_q;
    logic [DIV_W-1:0]  carrier_q;
    logic [7:0]        tick_q;
    logic [7:0]        tick_d;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;
    logic [7:0]        phase_q;
    logic [3:0]        match_q;
    logic              tick_pulse_q;
    logic              one_sec_q;
    logic              frame_start_q;
    logic              carrier_wrap;
    logic              tick_event;
    logic              addr_wrap;
    logic              phase_ok;
    logic              phase_match;
    logic              fsm_hunt;

    // Divisors of 0 or 1 both mean "every carrier pulse is a tick".
    assign carrier_wrap = (carrier_div <= DIV_W'(1)) ||
                          (carrier_q >= carrier_div - DIV_W'(1));
    assign tick_event   = carrier_pulse && carrier_wrap;
    assign addr_wrap    = (addr_q == ADDR_W'(FRAME_TICKS - 1));
    assign addr_d       = addr_wrap ? '0 : addr_q + ADDR_W'(1);
    assign tick_d       = (addr_wrap || tick_q == 8'(TICKS_PER_SEC - 1)) ? 8'd0 : tick_q + 8'd1;
    assign phase_ok     = phase_valid && ({1'b0, marker_phase} < 9'(TICKS_PER_SEC));
    assign phase_match  = (marker_phase == phase_q);

`ifdef TIMING_CTRL_WATCHDOG_EN
    localparam int WD_W = $clog2(WD_LIMIT + 1);

    logic [WD_W-1:0] wd_q;
    logic            lost_q;
    logic            wd_trip;

    assign wd_trip = !carrier_pulse && !lost_q && (wd_q == WD_W'(WD_LIMIT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_q   <= '0;
            lost_q <= 1'b0;
        end else if (carrier_pulse) begin
            wd_q   <= '0;
            lost_q <= 1'b0;
        end else if (!lost_q) begin
            wd_q <= wd_q + WD_W'(1);
            if (wd_trip) begin
                lost_q <= 1'b1;
            end
        end
    end

    assign fsm_hunt     = wd_trip || lost_q;
    assign carrier_lost = lost_q;
`else
    logic unused_wd_limit;
    assign unused_wd_limit = (WD_LIMIT > 0);
    assign fsm_hunt        = 1'b0;
    assign carrier_lost    = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= HUNT;
            carrier_q     <= '0;
            tick_q        <= '0;
            addr_q        <= '0;
            phase_q       <= '0;
            match_q       <= '0;
            tick_pulse_q  <= 1'b0;
            one_sec_q     <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            if (carrier_pulse) begin
                carrier_q <= carrier_wrap ? '0 : carrier_q + DIV_W'(1);
            end
            if (tick_event) begin
                tick_q <= tick_d;
                addr_q <= addr_d;
            end
            tick_pulse_q  <= tick_event;
            frame_start_q <= tick_event && addr_wrap;
            // Uses the pre-update state/phase, so a coincident report cannot steer this marker.
            one_sec_q     <= tick_event && (state_q == LOCKED) && (tick_d == phase_q);

            if (fsm_hunt) begin
                state_q <= HUNT;
                match_q <= '0;
            end else if (phase_ok) begin
                case (state_q)
                    HUNT: begin
                        phase_q <= marker_phase;
                        match_q <= 4'd1;
                        state_q <= QUAL;
                    end
                    QUAL: begin
                        if (phase_match) begin
                            match_q <= match_q + 4'd1;
                            if (match_q + 4'd1 == 4'(LOCK_COUNT)) begin
                                state_q <= LOCKED;
                            end
                        end else begin
                            phase_q <= marker_phase;
                            match_q <= 4'd1;
                        end
                    end
                    LOCKED: begin
                        if (!phase_match) begin
                            phase_q <= marker_phase;
                            match_q <= 4'd1;
                            state_q <= QUAL;
                        end
                    end
                    default: begin
                        state_q <= HUNT;
                        match_q <= '0;
                    end
                endcase
            end
        end
    end

    assign carrier_counter   = carrier_q;
    assign tick_counter      = tick_q;
    assign address_counter   = addr_q;
    assign tick_pulse        = tick_pulse_q;
    assign write_second_bram = {4{tick_pulse_q}};
    assign one_sec_marker    = one_sec_q;
    assign frame_start       = frame_start_q;
    assign locked            = (state_q == LOCKED);
endmodule

// File: tb/tb_timing_control_gen.sv
// tb/tb_timing_control_gen.sv - directed self-checking bench for timing_control_gen
module tb_timing_control_gen;
    localparam int DIV_W  = 9;
    localparam int ADDR_W = 12;

    logic              clk;
    logic              rst;
    logic              carrier_pulse;
    logic [DIV_W-1:0]  carrier_div;
    logic [7:0]        marker_phase;
    logic              phase_valid;
    logic [DIV_W-1:0]  carrier_counter;
    logic [7:0]        tick_counter;
    logic [ADDR_W-1:0] address_counter;
    logic              tick_pulse;
    logic [3:0]        write_second_bram;
    logic              one_sec_marker;
    logic              frame_start;
    logic              locked;
    logic              carrier_lost;

    int n_cmp = 0;
    int n_bad = 0;

    timing_control_gen #(
        .DIV_W(DIV_W), .TICKS_PER_SEC(250), .FRAME_SEC(16), .ADDR_W(ADDR_W),
        .LOCK_COUNT(4), .WD_LIMIT(200)
    ) dut (
        .clk(clk), .rst(rst), .carrier_pulse(carrier_pulse), .carrier_div(carrier_div),
        .marker_phase(marker_phase), .phase_valid(phase_valid),
        .carrier_counter(carrier_counter), .tick_counter(tick_counter),
        .address_counter(address_counter), .tick_pulse(tick_pulse),
        .write_second_bram(write_second_bram), .one_sec_marker(one_sec_marker),
        .frame_start(frame_start), .locked(locked), .carrier_lost(carrier_lost)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic apply_reset;
        rst = 1'b1;
        carrier_pulse = 1'b0;
        phase_valid = 1'b0;
        marker_phase = 8'd0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Holds carrier_pulse high for n cycles and tallies what the outputs show after each edge.
    task automatic run_pulses(input int n, input int mphase, output int ticks, output int wsb_f,
                              output int marks, output int frames, output int bad_marks);
        ticks = 0; wsb_f = 0; marks = 0; frames = 0; bad_marks = 0;
        carrier_pulse = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (tick_pulse) ticks++;
            if (write_second_bram == 4'hF) wsb_f++;
            if (frame_start) frames++;
            if (one_sec_marker) begin
                marks++;
                if (tick_counter != 8'(mphase) || !tick_pulse) bad_marks++;
            end
        end
        carrier_pulse = 1'b0;
    endtask

    task automatic report(input int p);
        marker_phase = 8'(p);
        phase_valid = 1'b1;
        @(negedge clk);
        phase_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        carrier_pulse = 1'b0;
        phase_valid = 1'b0;
        marker_phase = 8'd0;
        carrier_div = 9'd310;
        @(negedge clk);
        n_cmp++;
        if ({carrier_counter, tick_counter, address_counter} !== '0) begin
            n_bad++; $display("FAIL reset_counters: got %0d/%0d/%0d expected 0/0/0",
                              carrier_counter, tick_counter, address_counter);
        end
        n_cmp++;
        if ({tick_pulse, write_second_bram, one_sec_marker, frame_start, locked, carrier_lost} !== 9'd0) begin
            n_bad++; $display("FAIL reset_flags: got %b expected 0",
                              {tick_pulse, write_second_bram, one_sec_marker, frame_start, locked, carrier_lost});
        end
        rst = 1'b0;
    endtask

    task automatic test_carrier_div;
        int t, w, m, f, b;
        apply_reset();
        carrier_div = 9'd310;
        run_pulses(620, 0, t, w, m, f, b);
        n_cmp++;
        if (t !== 2) begin n_bad++; $display("FAIL div310_ticks: got %0d expected 2", t); end
        n_cmp++;
        if (w !== 2) begin n_bad++; $display("FAIL div310_wsb: got %0d expected 2", w); end
        n_cmp++;
        if (carrier_counter !== 9'd0) begin n_bad++; $display("FAIL div310_carrier: got %0d expected 0", carrier_counter); end
        n_cmp++;
        if (tick_counter !== 8'd2) begin n_bad++; $display("FAIL div310_tick: got %0d expected 2", tick_counter); end
        @(negedge clk);
        n_cmp++;
        if (write_second_bram !== 4'h0) begin n_bad++; $display("FAIL div310_wsb_idle: got %h expected 0", write_second_bram); end
    endtask

    task automatic test_frame;
        int t, w, m, f, b;
        apply_reset();
        carrier_div = 9'd1;
        run_pulses(3999, 0, t, w, m, f, b);
        n_cmp++;
        if (address_counter !== 12'd3999) begin n_bad++; $display("FAIL frame_addr_end: got %0d expected 3999", address_counter); end
        n_cmp++;
        if (tick_counter !== 8'd249) begin n_bad++; $display("FAIL frame_tick_end: got %0d expected 249", tick_counter); end
        n_cmp++;
        if (f !== 0) begin n_bad++; $display("FAIL frame_early_start: got %0d expected 0", f); end
        run_pulses(1, 0, t, w, m, f, b);
        n_cmp++;
        if (address_counter !== 12'd0 || tick_counter !== 8'd0) begin
            n_bad++; $display("FAIL frame_wrap: got addr %0d tick %0d expected 0 0", address_counter, tick_counter);
        end
        n_cmp++;
        if (frame_start !== 1'b1 || tick_pulse !== 1'b1) begin
            n_bad++; $display("FAIL frame_start_pulse: got %b%b expected 11", frame_start, tick_pulse);
        end
        @(negedge clk);
        n_cmp++;
        if (frame_start !== 1'b0) begin n_bad++; $display("FAIL frame_start_width: got %b expected 0", frame_start); end
    endtask

    task automatic test_lock;
        int t, w, m, f, b;
        apply_reset();
        carrier_div = 9'd1;
        report(17); report(17); report(17);
        n_cmp++;
        if (locked !== 1'b0) begin n_bad++; $display("FAIL lock_early: got %b expected 0", locked); end
        report(17);
        n_cmp++;
        if (locked !== 1'b1) begin n_bad++; $display("FAIL lock_fourth: got %b expected 1", locked); end
        run_pulses(500, 17, t, w, m, f, b);
        n_cmp++;
        if (m !== 2 || b !== 0) begin n_bad++; $display("FAIL lock_markers: got %0d (bad %0d) expected 2 (bad 0)", m, b); end
        report(18);
        n_cmp++;
        if (locked !== 1'b0) begin n_bad++; $display("FAIL lock_drop: got %b expected 0", locked); end
        run_pulses(250, 17, t, w, m, f, b);
        n_cmp++;
        if (m !== 0) begin n_bad++; $display("FAIL lock_no_marker: got %0d expected 0", m); end
    endtask

    task automatic test_phase_ignore;
        int t, w, m, f, b;
        apply_reset();
        carrier_div = 9'd1;
        report(17); report(17); report(17);
        report(250); report(255);
        n_cmp++;
        if (locked !== 1'b0) begin n_bad++; $display("FAIL ignore_locked: got %b expected 0", locked); end
        report(17);
        n_cmp++;
        if (locked !== 1'b1) begin n_bad++; $display("FAIL ignore_count_kept: got %b expected 1", locked); end
        run_pulses(250, 17, t, w, m, f, b);
        n_cmp++;
        if (m !== 1 || b !== 0) begin n_bad++; $display("FAIL ignore_phase_kept: got %0d (bad %0d) expected 1 (bad 0)", m, b); end
    endtask

    task automatic test_div_change;
        int t, w, m, f, b;
        apply_reset();
        carrier_div = 9'd310;
        run_pulses(300, 0, t, w, m, f, b);
        n_cmp++;
        if (carrier_counter !== 9'd300 || t !== 0) begin
            n_bad++; $display("FAIL divchg_pre: got cnt %0d ticks %0d expected 300 0", carrier_counter, t);
        end
        carrier_div = 9'd240;
        run_pulses(1, 0, t, w, m, f, b);
        n_cmp++;
        if (carrier_counter !== 9'd0 || t !== 1 || tick_counter !== 8'd1) begin
            n_bad++; $display("FAIL divchg_wrap: got cnt %0d ticks %0d tick %0d expected 0 1 1", carrier_counter, t, tick_counter);
        end
        run_pulses(239, 0, t, w, m, f, b);
        n_cmp++;
        if (carrier_counter !== 9'd239 || t !== 0) begin
            n_bad++; $display("FAIL divchg_run: got cnt %0d ticks %0d expected 239 0", carrier_counter, t);
        end
        run_pulses(1, 0, t, w, m, f, b);
        n_cmp++;
        if (carrier_counter !== 9'd0 || t !== 1 || tick_counter !== 8'd2) begin
            n_bad++; $display("FAIL divchg_240: got cnt %0d ticks %0d tick %0d expected 0 1 2", carrier_counter, t, tick_counter);
        end
    endtask

    task automatic test_back_to_back;
        int t, w, m, f, b;
        apply_reset();
        carrier_div = 9'd0;
        run_pulses(5, 0, t, w, m, f, b);
        n_cmp++;
        if (t !== 5 || tick_counter !== 8'd5 || carrier_counter !== 9'd0) begin
            n_bad++; $display("FAIL div0: got ticks %0d tick %0d cnt %0d expected 5 5 0", t, tick_counter, carrier_counter);
        end
        carrier_div = 9'd1;
        run_pulses(3, 0, t, w, m, f, b);
        n_cmp++;
        if (t !== 3 || tick_counter !== 8'd8) begin
            n_bad++; $display("FAIL div1: got ticks %0d tick %0d expected 3 8", t, tick_counter);
        end
    endtask

    task automatic test_coincide;
        int t, w, m, f, b;
        apply_reset();
        carrier_div = 9'd1;
        report(17); report(17); report(17); report(17);
        run_pulses(16, 17, t, w, m, f, b);
        carrier_pulse = 1'b1;
        phase_valid = 1'b1;
        marker_phase = 8'd20;
        @(negedge clk);
        carrier_pulse = 1'b0;
        phase_valid = 1'b0;
        n_cmp++;
        if (one_sec_marker !== 1'b1 || tick_counter !== 8'd17) begin
            n_bad++; $display("FAIL coincide_marker: got %b at tick %0d expected 1 at 17", one_sec_marker, tick_counter);
        end
        n_cmp++;
        if (locked !== 1'b0) begin n_bad++; $display("FAIL coincide_unlock: got %b expected 0", locked); end
    endtask

    task automatic test_reset_mid;
        int t, w, m, f, b;
        apply_reset();
        carrier_div = 9'd1;
        report(17); report(17);
        run_pulses(5, 17, t, w, m, f, b);
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (tick_counter !== 8'd0 || tick_pulse !== 1'b0) begin
            n_bad++; $display("FAIL rst_async: got tick %0d pulse %b expected 0 0", tick_counter, tick_pulse);
        end
        @(negedge clk);
        rst = 1'b0;
        report(17); report(17); report(17);
        n_cmp++;
        if (locked !== 1'b0) begin n_bad++; $display("FAIL rst_qual_cleared: got %b expected 0", locked); end
        report(17);
        n_cmp++;
        if (locked !== 1'b1) begin n_bad++; $display("FAIL rst_relock: got %b expected 1", locked); end
    endtask

`ifdef TIMING_CTRL_WATCHDOG_EN
    task automatic test_watchdog;
        int t, w, m, f, b;
        apply_reset();
        carrier_div = 9'd1;
        report(17); report(17); report(17); report(17);
        run_pulses(10, 17, t, w, m, f, b);
        repeat (199) @(negedge clk);
        n_cmp++;
        if (carrier_lost !== 1'b0 || locked !== 1'b1) begin
            n_bad++; $display("FAIL wd_before: got lost %b locked %b expected 0 1", carrier_lost, locked);
        end
        @(negedge clk);
        n_cmp++;
        if (carrier_lost !== 1'b1 || locked !== 1'b0) begin
            n_bad++; $display("FAIL wd_trip: got lost %b locked %b expected 1 0", carrier_lost, locked);
        end
        repeat (50) @(negedge clk);
        n_cmp++;
        if (tick_counter !== 8'd10 || address_counter !== 12'd10 || carrier_counter !== 9'd0) begin
            n_bad++; $display("FAIL wd_frozen: got %0d/%0d/%0d expected 10/10/0", tick_counter, address_counter, carrier_counter);
        end
        run_pulses(1, 17, t, w, m, f, b);
        n_cmp++;
        if (carrier_lost !== 1'b0 || tick_counter !== 8'd11) begin
            n_bad++; $display("FAIL wd_resume: got lost %b tick %0d expected 0 11", carrier_lost, tick_counter);
        end
        repeat (250) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({carrier_counter, tick_counter, address_counter, tick_pulse, write_second_bram,
             one_sec_marker, frame_start, locked, carrier_lost} !== '0) begin
            n_bad++; $display("FAIL wd_rst: got lost %b tick %0d expected all 0", carrier_lost, tick_counter);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask
`else
    task automatic test_watchdog;
        apply_reset();
        carrier_div = 9'd1;
        repeat (300) @(negedge clk);
        n_cmp++;
        if (carrier_lost !== 1'b0) begin n_bad++; $display("FAIL no_wd_lost: got %b expected 0", carrier_lost); end
    endtask
`endif

    initial begin
        test_reset();
        test_carrier_div();
        test_frame();
        test_lock();
        test_phase_ignore();
        test_div_change();
        test_back_to_back();
        test_coincide();
        test_reset_mid();
        test_watchdog();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
